serial_ula_scheduler: RTL and testbench
=======================================

# serial_ula_scheduler

Sequences and shares the serial ULA between a cassette client and an RS423 client. The block owns the ULA control-register write path and arbitrates access between the two clients. For cassette sessions it switches the motor on, waits a fixed spin-up time and, for loads, waits for high-tone carrier detect before granting. It sits between the two client engines and the ULA's 6502-side control write port.

## Interface
- `MOTOR_SPINUP`, default 16: cycles spent in SPINUP; must be ≥1.
- `DCD_TIMEOUT`, default 4096: cycles allowed in WAIT_TONE; must be ≥1.
- `IDLE_CTRL`, default 8'h40: control byte written when no cassette session is active (RS423 selected, motor off).
- `clk` in 1: single clock; all logic on its rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `cas_req` in 1: cassette client request; level, held for the whole session.
- `cas_dir` in 1: 0 = load (wait for tone), 1 = save; sampled at grant.
- `cas_baud` in 6: {rx[2:0], tx[2:0]} for the cassette session; sampled at grant.
- `rs_req` in 1: RS423 client request; level.
- `rs_baud` in 6: {rx[2:0], tx[2:0]} for RS423; sampled at grant.
- `dcd` in 1: ULA carrier detect; asynchronous, synchronised internally with 2 flops.
- `ctl_wr` out 1: one-cycle control-register write strobe.
- `ctl_data` out 8: control byte. Valid with `ctl_wr`; held until the next write.
- `cas_gnt` out 1: cassette owns the ULA (SPINUP, WAIT_TONE, CAS_ACTIVE).
- `cas_ready` out 1: cassette may transfer (CAS_ACTIVE only).
- `cas_timeout` out 1: one-cycle pulse when the tone wait expires.
- `rs_gnt` out 1: RS423 owns the ULA (RS_ACTIVE).
- `busy` out 1: high in every state except IDLE.

## Operation
Control byte layout: [7] motor, [6] rs423_sel, [5:3] rx baud, [2:0] tx baud.

State machine:
- **INIT** (reset state): `ctl_wr`=1, `ctl_data`=IDLE_CTRL, then go to IDLE.
- **IDLE**: arbitrate between requests.
  - Only `cas_req` (and not locked) → CFG_CAS.
  - Only `rs_req` → CFG_RS.
  - Both → round-robin: grant the client not granted last. The `last` flag resets to RS, so cassette wins the first tie.
- **CFG_RS**: `ctl_wr`=1, `ctl_data`={1'b0, 1'b1, rs_baud}, then go to RS_ACTIVE.
- **RS_ACTIVE**: `rs_gnt`=1. When `rs_req` drops → RELEASE.
- **CFG_CAS**: `ctl_wr`=1, `ctl_data`={1'b1, 1'b0, cas_baud}; latch `cas_dir`. Go to SPINUP.
- **SPINUP**: exactly MOTOR_SPINUP cycles, then WAIT_TONE if load, or CAS_ACTIVE if save.
- **WAIT_TONE**: go to CAS_ACTIVE the cycle after synchronised dcd=1. If the count reaches DCD_TIMEOUT first: pulse `cas_timeout`, set the cassette lock, go to RELEASE.
- **CAS_ACTIVE**: `cas_ready`=1. When `cas_req` drops → RELEASE.
- **RELEASE**: `ctl_wr`=1, `ctl_data`=IDLE_CTRL (motor off), then go to IDLE.

Rules:
- If `cas_req` drops during SPINUP or WAIT_TONE: go to RELEASE the next cycle; no timeout pulse.
- Cassette lock: set on timeout, cleared in any cycle where `cas_req`=0. While locked, a held `cas_req` is ignored and `rs_req` may be served.
- Counter: one shared down-counter, width $clog2(max(MOTOR_SPINUP, DCD_TIMEOUT)+1). Loaded on entry to SPINUP and WAIT_TONE; never wraps.
- `cas_dir` and the baud inputs are don't-care outside their CFG state.

## Timing
- Reset values: `ctl_wr`=0, `ctl_data`=IDLE_CTRL, all grants, `cas_ready`, `cas_timeout` and `busy` = 0; state INIT; lock=0; `last`=RS; synchroniser flops = 0.
- First cycle after `nRST` rises: INIT write (`ctl_wr`=1).
- Reset asserted mid-session: all outputs return to reset values immediately. The ULA motor is switched off by the INIT write after release.
- Request sampled in IDLE at cycle N: `ctl_wr` at N+1, grant from N+2.
- Save session: `cas_ready` rises MOTOR_SPINUP cycles after `cas_gnt` rises.
- Load session: `dcd` edge to `cas_ready` is 3 cycles (2 synchroniser + 1 state).
- Release: req low at cycle N → grant and `cas_ready` low at N+1, RELEASE `ctl_wr` at N+1, IDLE at N+2.
- Minimum gap between two sessions: 1 IDLE cycle.

## Test plan
- Reset release with no requests → exactly one `ctl_wr` with 8'h40, one cycle after release; `busy`=0 thereafter.
- RS only, `rs_baud`=6'b100_100 → `ctl_data`=8'h64, `rs_gnt` 2 cycles after request; drop → `ctl_data`=8'h40 write.
- Cassette save, `cas_baud`=6'b001_001, MOTOR_SPINUP=16 → `ctl_data`=8'h89; `cas_ready` 16 cycles after `cas_gnt`.
- Cassette load with `dcd` rising 100 cycles into WAIT_TONE → `cas_ready` 3 cycles later; no `cas_timeout`.
- Load with `dcd`=0, DCD_TIMEOUT=32 → `cas_timeout` pulse after 32 cycles; 8'h40 write. With `cas_req` held, `rs_req` is then granted and cassette is not, until `cas_req` toggles low.
- Both requests asserted together three times in a row → grants cas, rs, cas; `nRST` pulsed during CAS_ACTIVE → outputs zero immediately, INIT write follows.

Source files
------------

// File: rtl/serial_ula_scheduler.sv
// serial_ula_scheduler: shares the serial ULA between a cassette client and an
// RS423 client, and owns the ULA control-register write path.
module serial_ula_scheduler #(
    parameter int unsigned MOTOR_SPINUP = 16,
    parameter int unsigned DCD_TIMEOUT  = 4096,
    parameter logic [7:0]  IDLE_CTRL    = 8'h40
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       cas_req,
    input  logic       cas_dir,
    input  logic [5:0] cas_baud,
    input  logic       rs_req,
    input  logic [5:0] rs_baud,
    input  logic       dcd,
    output logic       ctl_wr,
    output logic [7:0] ctl_data,
    output logic       cas_gnt,
    output logic       cas_ready,
    output logic       cas_timeout,
    output logic       rs_gnt,
    output logic       busy,
    output logic [3:0] dbg_state
);

    localparam int unsigned CNT_MAX = (MOTOR_SPINUP > DCD_TIMEOUT) ? MOTOR_SPINUP : DCD_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] SPIN_LOAD = CNT_W'(MOTOR_SPINUP);
    localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(DCD_TIMEOUT);

    typedef enum logic [3:0] {
        S_INIT       = 4'd0,
        S_IDLE       = 4'd1,
        S_CFG_RS     = 4'd2,
        S_RS_ACTIVE  = 4'd3,
        S_CFG_CAS    = 4'd4,
        S_SPINUP     = 4'd5,
        S_WAIT_TONE  = 4'd6,
        S_CAS_ACTIVE = 4'd7,
        S_RELEASE    = 4'd8
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic             last_cas_q, last_cas_d;
    logic             dir_q, dir_d;
    logic             dcd_meta_q, dcd_sync_q;
    logic             timeout_hit;
    logic             cas_eff;

    logic             ctl_wr_q, ctl_wr_d;
    logic [7:0]       ctl_data_q, ctl_data_d;
    logic             cas_gnt_q, cas_gnt_d;
    logic             cas_ready_q, cas_ready_d;
    logic             cas_timeout_q;
    logic             rs_gnt_q, rs_gnt_d;
    logic             busy_q, busy_d;

    // Requests are levels held for the whole session; a grant (and cas_ready)
    // is the acknowledgement, and dropping the request ends the session.
    assign cas_eff = cas_req && !lock_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lock_d      = lock_q;
        last_cas_d  = last_cas_q;
        dir_d       = dir_q;
        timeout_hit = 1'b0;
        if (!cas_req) begin
            lock_d = 1'b0;
        end
        case (state_q)
            S_INIT: state_d = S_IDLE;
            S_IDLE: begin
                if (cas_eff && (!rs_req || !last_cas_q)) begin
                    state_d    = S_CFG_CAS;
                    last_cas_d = 1'b1;
                end else if (rs_req) begin
                    state_d    = S_CFG_RS;
                    last_cas_d = 1'b0;
                end
            end
            S_CFG_RS: state_d = S_RS_ACTIVE;
            S_RS_ACTIVE: begin
                if (!rs_req) state_d = S_RELEASE;
            end
            S_CFG_CAS: begin
                state_d = S_SPINUP;
                cnt_d   = SPIN_LOAD;
                dir_d   = cas_dir;
            end
            S_SPINUP: begin
                if (!cas_req) begin
                    state_d = S_RELEASE;
                end else if (cnt_q <= CNT_ONE) begin
                    if (dir_q) begin
                        state_d = S_CAS_ACTIVE;
                    end else begin
                        state_d = S_WAIT_TONE;
                        cnt_d   = TONE_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_WAIT_TONE: begin
                // A dropped request wins over tone and timeout: no pulse, no lock.
                if (!cas_req) begin
                    state_d = S_RELEASE;
                end else if (dcd_sync_q) begin
                    state_d = S_CAS_ACTIVE;
                end else if (cnt_q <= CNT_ONE) begin
                    state_d     = S_RELEASE;
                    timeout_hit = 1'b1;
                    lock_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_CAS_ACTIVE: begin
                if (!cas_req) state_d = S_RELEASE;
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_INIT;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up
    // with the state itself while still resetting to zero.
    always_comb begin
        ctl_wr_d   = 1'b0;
        ctl_data_d = ctl_data_q;
        if (state_q == S_INIT) begin
            ctl_wr_d   = 1'b1;
            ctl_data_d = IDLE_CTRL;
        end
        case (state_d)
            S_CFG_RS: begin
                ctl_wr_d   = 1'b1;
                ctl_data_d = {1'b0, 1'b1, rs_baud};
            end
            S_CFG_CAS: begin
                ctl_wr_d   = 1'b1;
                ctl_data_d = {1'b1, 1'b0, cas_baud};
            end
            S_RELEASE: begin
                ctl_wr_d   = 1'b1;
                ctl_data_d = IDLE_CTRL;
            end
            default: ;
        endcase
    end

    assign cas_gnt_d   = (state_d == S_SPINUP) || (state_d == S_WAIT_TONE) || (state_d == S_CAS_ACTIVE);
    assign cas_ready_d = (state_d == S_CAS_ACTIVE);
    assign rs_gnt_d    = (state_d == S_RS_ACTIVE);
    assign busy_d      = (state_d != S_IDLE);

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            lock_q        <= 1'b0;
            last_cas_q    <= 1'b0;
            dir_q         <= 1'b0;
            dcd_meta_q    <= 1'b0;
            dcd_sync_q    <= 1'b0;
            ctl_wr_q      <= 1'b0;
            ctl_data_q    <= IDLE_CTRL;
            cas_gnt_q     <= 1'b0;
            cas_ready_q   <= 1'b0;
            cas_timeout_q <= 1'b0;
            rs_gnt_q      <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lock_q        <= lock_d;
            last_cas_q    <= last_cas_d;
            dir_q         <= dir_d;
            dcd_meta_q    <= dcd;
            dcd_sync_q    <= dcd_meta_q;
            ctl_wr_q      <= ctl_wr_d;
            ctl_data_q    <= ctl_data_d;
            cas_gnt_q     <= cas_gnt_d;
            cas_ready_q   <= cas_ready_d;
            cas_timeout_q <= timeout_hit;
            rs_gnt_q      <= rs_gnt_d;
            busy_q        <= busy_d;
        end
    end

    assign ctl_wr      = ctl_wr_q;
    assign ctl_data    = ctl_data_q;
    assign cas_gnt     = cas_gnt_q;
    assign cas_ready   = cas_ready_q;
    assign cas_timeout = cas_timeout_q;
    assign rs_gnt      = rs_gnt_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_ula_scheduler.sv
// tb_serial_ula_scheduler: randomized sessions against a timeline/arbitration
// model of the scheduler; control-register writes are matched through exp_q.
module tb_serial_ula_scheduler;

    localparam int         SPIN      = 16;
    localparam int         TMO       = 128;
    localparam logic [7:0] IDLE_BYTE = 8'h40;

    logic       clk = 1'b0;
    logic       nRST;
    logic       cas_req, cas_dir, rs_req, dcd;
    logic [5:0] cas_baud, rs_baud;
    logic       ctl_wr, cas_gnt, cas_ready, cas_timeout, rs_gnt, busy;
    logic [7:0] ctl_data;
    logic [3:0] dbg_state;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    int         to_seen  = 0;
    bit         model_last_cas;
    bit         model_lock;

    serial_ula_scheduler #(
        .MOTOR_SPINUP(SPIN),
        .DCD_TIMEOUT (TMO),
        .IDLE_CTRL   (IDLE_BYTE)
    ) dut (
        .clk        (clk),
        .nRST       (nRST),
        .cas_req    (cas_req),
        .cas_dir    (cas_dir),
        .cas_baud   (cas_baud),
        .rs_req     (rs_req),
        .rs_baud    (rs_baud),
        .dcd        (dcd),
        .ctl_wr     (ctl_wr),
        .ctl_data   (ctl_data),
        .cas_gnt    (cas_gnt),
        .cas_ready  (cas_ready),
        .cas_timeout(cas_timeout),
        .rs_gnt     (rs_gnt),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // scoreboard: every control write must match the oldest expected byte
    always @(negedge clk) begin
        if (nRST) begin
            if (cas_timeout) to_seen++;
            if (ctl_wr) begin
                if (exp_q.size() == 0) check("unexpected_wr", ctl_wr, 1'b0);
                else check("wr_data", ctl_data, exp_q.pop_front());
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // reference arbitration: cassette wins unless locked or it was served last in a tie
    function automatic bit pick_cas(input bit cas, input bit rs);
        return cas && !model_lock && (!rs || !model_last_cas);
    endfunction

    // driver tasks
    task automatic apply_reset();
        nRST = 1'b0;
        #1;
        check("rst_ctl_wr", ctl_wr, 1'b0);
        check("rst_ctl_data", ctl_data, IDLE_BYTE);
        check("rst_gnts", {cas_gnt, rs_gnt, cas_ready, cas_timeout}, 4'b0000);
        check("rst_busy", busy, 1'b0);
        cas_req = 1'b0; rs_req = 1'b0; dcd = 1'b0; cas_dir = 1'b0;
        exp_q.delete();
        step(3);
        model_last_cas = 1'b0;
        model_lock     = 1'b0;
        nRST = 1'b1;
        exp_q.push_back(IDLE_BYTE);
        step(1);
        check("init_wr", ctl_wr, 1'b1);
        check("init_busy", busy, 1'b0);
        step(2);
        check("post_init_wr", ctl_wr, 1'b0);
        check("post_init_busy", busy, 1'b0);
        check("init_drained", exp_q.size(), 0);
    endtask

    task automatic rs_session(input logic [5:0] baud, input int hold);
        rs_baud = baud;
        rs_req  = 1'b1;
        exp_q.push_back({2'b01, baud});
        step(1);
        check("rs_cfg_wr", ctl_wr, 1'b1);
        check("rs_cfg_no_gnt", rs_gnt, 1'b0);
        step(1);
        check("rs_gnt", rs_gnt, 1'b1);
        check("rs_no_cas_gnt", cas_gnt, 1'b0);
        check("rs_busy", busy, 1'b1);
        model_last_cas = 1'b0;
        rs_baud = 6'($urandom);
        step(hold);
        check("rs_gnt_held", rs_gnt, 1'b1);
        check("rs_data_held", {ctl_wr, ctl_data}, {1'b0, 2'b01, baud});
        rs_req = 1'b0;
        exp_q.push_back(IDLE_BYTE);
        step(1);
        check("rs_rel_gnt", rs_gnt, 1'b0);
        check("rs_rel_wr", ctl_wr, 1'b1);
        step(1);
        check("rs_idle", busy, 1'b0);
    endtask

    task automatic cas_open(input logic [5:0] baud, input logic dir);
        cas_baud = baud;
        cas_dir  = dir;
        cas_req  = 1'b1;
        exp_q.push_back({2'b10, baud});
        step(1);
        check("cas_cfg_wr", ctl_wr, 1'b1);
        check("cas_cfg_no_gnt", cas_gnt, 1'b0);
        step(1);
        check("cas_gnt", cas_gnt, 1'b1);
        check("cas_not_ready", cas_ready, 1'b0);
        check("cas_no_rs_gnt", rs_gnt, 1'b0);
        model_last_cas = 1'b1;
        cas_baud = 6'($urandom);
        cas_dir  = 1'($urandom);
    endtask

    task automatic cas_wait_save();
        int n = 0;
        while (!cas_ready && n < SPIN + 8) begin
            step(1);
            n++;
        end
        check("save_spinup_cycles", n, SPIN);
    endtask

    task automatic cas_load(input int dly);
        int t0 = to_seen;
        step(SPIN);
        check("load_wait_gnt", cas_gnt, 1'b1);
        check("load_wait_not_ready", cas_ready, 1'b0);
        step(dly);
        dcd = 1'b1;
        step(2);
        check("load_dcd_2cyc", cas_ready, 1'b0);
        step(1);
        check("load_dcd_3cyc", cas_ready, 1'b1);
        check("load_no_timeout", to_seen, t0);
    endtask

    task automatic cas_close();
        cas_req = 1'b0;
        exp_q.push_back(IDLE_BYTE);
        step(1);
        check("cas_rel_gnt", {cas_gnt, cas_ready}, 2'b00);
        check("cas_rel_wr", ctl_wr, 1'b1);
        check("cas_rel_no_to", cas_timeout, 1'b0);
        dcd = 1'b0;
        model_lock = 1'b0;
        step(1);
        check("cas_idle", busy, 1'b0);
    endtask

    task automatic cas_timeout_run();
        step(SPIN);
        step(TMO - 1);
        check("to_not_yet", cas_timeout, 1'b0);
        check("to_still_gnt", cas_gnt, 1'b1);
        exp_q.push_back(IDLE_BYTE);
        step(1);
        check("to_pulse", cas_timeout, 1'b1);
        check("to_gnt_low", cas_gnt, 1'b0);
        check("to_rel_wr", ctl_wr, 1'b1);
        model_lock = 1'b1;
        step(1);
        check("to_pulse_end", cas_timeout, 1'b0);
        check("to_idle", busy, 1'b0);
    endtask

    task automatic tie_round();
        logic [5:0] cb, rb;
        bit         exp_cas;
        cb = 6'($urandom);
        rb = 6'($urandom);
        exp_cas  = pick_cas(1'b1, 1'b1);
        cas_baud = cb; rs_baud = rb; cas_dir = 1'b1;
        cas_req  = 1'b1; rs_req = 1'b1;
        exp_q.push_back(exp_cas ? {2'b10, cb} : {2'b01, rb});
        step(1);
        check("tie_wr", ctl_wr, 1'b1);
        step(1);
        check("tie_cas_gnt", cas_gnt, exp_cas);
        check("tie_rs_gnt", rs_gnt, !exp_cas);
        model_last_cas = exp_cas;
        step($urandom_range(1, 4));
        cas_req = 1'b0; rs_req = 1'b0;
        exp_q.push_back(IDLE_BYTE);
        step(1);
        check("tie_rel_gnts", {cas_gnt, rs_gnt, cas_timeout}, 3'b000);
        step(1);
        check("tie_idle", busy, 1'b0);
    endtask

    initial begin
        nRST = 1'b1;
        cas_req = 1'b0; cas_dir = 1'b0; cas_baud = '0;
        rs_req = 1'b0; rs_baud = '0; dcd = 1'b0;
        #2;
        apply_reset();

        rs_session(6'b100_100, 5);
        cas_open(6'b001_001, 1'b1);
        check("save_ctl_byte", ctl_data, 8'h89);
        cas_wait_save();
        step(3);
        cas_close();
        cas_open(6'($urandom), 1'b0);
        cas_load(100);
        cas_close();

        // timeout, then the held cassette request stays locked out
        cas_open(6'($urandom), 1'b0);
        cas_timeout_run();
        step(3);
        check("lock_cas_ignored", {busy, cas_gnt}, 2'b00);
        check("lock_model", pick_cas(cas_req, 1'b0), 1'b0);
        rs_session(6'($urandom), 3);
        step(3);
        check("lock_after_rs", {busy, cas_gnt}, 2'b00);
        cas_req = 1'b0;
        step(1);
        model_lock = 1'b0;
        cas_open(6'($urandom), 1'b1);
        cas_wait_save();
        cas_close();

        // ties right after reset: cas, rs, cas
        apply_reset();
        for (int i = 0; i < 3; i++) tie_round();

        // reset during CAS_ACTIVE
        cas_open(6'($urandom), 1'b1);
        cas_wait_save();
        apply_reset();

        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 3))
                0: rs_session(6'($urandom), $urandom_range(1, 10));
                1: begin
                    cas_open(6'($urandom), 1'b1);
                    cas_wait_save();
                    step($urandom_range(1, 5));
                    cas_close();
                end
                2: begin
                    cas_open(6'($urandom), 1'b0);
                    cas_load($urandom_range(0, TMO - 8));
                    cas_close();
                end
                default: tie_round();
            endcase
            step($urandom_range(0, 3));
        end

        step(4);
        check("final_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
